// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// States, RV32I funct3 width codes, byte strobes and decode helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] WSTRB_B = 4'b0001;
  localparam logic [3:0] WSTRB_H = 4'b0011;
  localparam logic [3:0] WSTRB_W = 4'b1111;

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] f3_wstrb(
    input logic [2:0] f3
  );
    logic [3:0] s;
    s = WSTRB_W;
    case (f3)
      F3_B:    s = WSTRB_B;
      F3_H:    s = WSTRB_H;
      default: s = WSTRB_W;
    endcase
    return s;
  endfunction

  function automatic logic f3_misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic m;
    m = 1'b0;
    case (f3)
      F3_H, F3_HU: m = lo[0];
      F3_W:        m = (lo != 2'b00);
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// Load data extension: picks byte/half/word from the raw read
// word and sign- or zero-extends it according to funct3.
module load_extender
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  // Width/sign select on the unshifted low bits of the read word
  always_comb begin
    o_data = i_data;
    unique case (i_funct3)
      F3_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
      F3_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
      F3_BU:   o_data = {24'd0, i_data[7:0]};
      F3_HU:   o_data = {16'd0, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between core and memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  input  logic              mem_read_valid,
  input  logic [31:0]       mem_read_data,
  output logic              mem_write_enable,
  output logic [3:0]        mem_write_wstrb,
  output logic [31:0]       mem_write_data,
  input  logic              mem_write_ready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_wdata;

  logic        w_accept;
  logic        w_legal;
  logic        w_mis;
  logic        w_cnt_last;
  logic [31:0] w_ext;

  assign w_accept   = req_valid & r_req_ready;
  assign w_legal    = f3_legal(req_we, req_funct3);
  assign w_cnt_last = (r_cnt == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = f3_misaligned(req_funct3, req_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  load_extender u_ext (
    .i_funct3 (r_funct3),
    .i_data   (mem_read_data),
    .o_data   (w_ext)
  );

  // Control FSM, wait counter and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_funct3     <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_wstrb      <= '0;
      r_wdata      <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_funct3    <= req_funct3;
            r_mem_addr  <= req_addr;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            if (!w_legal || w_mis) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (req_we) begin
              r_state  <= ST_WRITE;
              r_mem_we <= 1'b1;
              r_wstrb  <= f3_wstrb(req_funct3);
              r_wdata  <= req_wdata;
            end else begin
              r_state  <= ST_READ;
              r_mem_re <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (mem_read_valid) begin
            r_state      <= ST_RESP;
            r_mem_re     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_ext;
          end else if (w_cnt_last) begin
            r_state      <= ST_RESP;
            r_mem_re     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (mem_write_ready || w_cnt_last) begin
            r_state      <= ST_RESP;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= !mem_write_ready;
            r_resp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready        = r_req_ready;
  assign resp_valid       = r_resp_valid;
  assign resp_rdata       = r_resp_rdata;
  assign resp_err         = r_resp_err;
  assign mem_address      = r_mem_addr;
  assign mem_read_enable  = r_mem_re;
  assign mem_write_enable = r_mem_we;
  assign mem_write_wstrb  = r_wstrb;
  assign mem_write_data   = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a latency-tunable
// word memory model; honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read_enable;
  logic        mem_read_valid;
  logic [31:0] mem_read_data;
  logic        mem_write_enable;
  logic [3:0]  mem_write_wstrb;
  logic [31:0] mem_write_data;
  logic        mem_write_ready;

  load_store_unit #(
    .TIMEOUT_CYCLES (16),
    .ADDR_W         (32)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_address      (mem_address),
    .mem_read_enable  (mem_read_enable),
    .mem_read_valid   (mem_read_valid),
    .mem_read_data    (mem_read_data),
    .mem_write_enable (mem_write_enable),
    .mem_write_wstrb  (mem_write_wstrb),
    .mem_write_data   (mem_write_data),
    .mem_write_ready  (mem_write_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_word [0:63];
  int          m_cnt;
  int          m_lat_cfg;
  logic        m_stray;
  logic        w_en_any;

  assign w_en_any = mem_read_enable | mem_write_enable;
  assign mem_read_valid =
    (mem_read_enable && m_cnt == m_lat_cfg) || m_stray;
  assign mem_write_ready =
    mem_write_enable && m_cnt == m_lat_cfg;
  assign mem_read_data = m_word[mem_address[7:2]];

  initial m_cnt = 0;

  always @(posedge clk) begin
    m_cnt <= w_en_any ? m_cnt + 1 : 0;
    if (mem_write_enable && mem_write_ready) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_write_wstrb[b])
          m_word[mem_address[7:2]][8*b +: 8] <=
            mem_write_data[8*b +: 8];
      end
    end
  end

  int n_cmp;
  int n_bad;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               tag, got, exp);
    end
  endtask

  int          t_lat;
  int          t_en;
  logic [31:0] t_rd;
  logic        t_err;
  logic [31:0] t_addr;
  logic [3:0]  t_strb;
  logic [31:0] t_wd;
  logic        t_busy;
  logic        t_pulse1;

  task automatic grab();
    if (w_en_any) begin
      t_en++;
      t_addr = mem_address;
      t_strb = mem_write_wstrb;
      t_wd   = mem_write_data;
    end
  endtask

  // One access; t_lat counts cycles after the accept edge
  task automatic xact(
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd
  );
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    t_lat  = 1;
    t_en   = 0;
    t_addr = '0;
    t_strb = '0;
    t_wd   = '0;
    t_busy = !req_ready;
    grab();
    while (!resp_valid && t_lat < 40) begin
      @(posedge clk);
      #1;
      t_lat++;
      grab();
    end
    t_rd  = resp_rdata;
    t_err = resp_err;
    @(posedge clk);
    #1;
    t_pulse1 = !resp_valid && req_ready;
  endtask

  int n_seen;

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    m_lat_cfg  = 1;
    m_stray    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_re", 32'(mem_read_enable), 32'd0);
    chk("rst_we", 32'(mem_write_enable), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_rdy", 32'(req_ready), 32'd1);

    xact(1'b1, 3'b010, 32'h10, 32'h3322_1180);
    chk("sw_strb", 32'(t_strb), 32'hF);
    chk("sw_lat", 32'(t_lat), 32'd3);
    chk("sw_err", 32'(t_err), 32'd0);

    xact(1'b0, 3'b000, 32'h10, 32'h0);
    chk("lb_lat", 32'(t_lat), 32'd3);
    chk("lb_rd", t_rd, 32'hFFFF_FF80);
    chk("lb_err", 32'(t_err), 32'd0);
    chk("lb_en", 32'(t_en), 32'd2);
    chk("lb_busy", 32'(t_busy), 32'd1);
    chk("lb_pulse", 32'(t_pulse1), 32'd1);

    xact(1'b0, 3'b100, 32'h10, 32'h0);
    chk("lbu_rd", t_rd, 32'h0000_0080);
    xact(1'b0, 3'b001, 32'h10, 32'h0);
    chk("lh_rd", t_rd, 32'h0000_1180);
    xact(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_rd", t_rd, 32'h3322_1180);

    xact(1'b1, 3'b010, 32'h20, 32'h0);
    xact(1'b1, 3'b001, 32'h20, 32'hAABB_CCDD);
    chk("sh_strb", 32'(t_strb), 32'h3);
    chk("sh_wd", t_wd, 32'hAABB_CCDD);
    chk("sh_addr", t_addr, 32'h20);
    chk("sh_rd", t_rd, 32'h0);
    xact(1'b0, 3'b010, 32'h20, 32'h0);
    chk("lw_sh", t_rd, 32'h0000_CCDD);
    xact(1'b0, 3'b001, 32'h20, 32'h0);
    chk("lh_neg", t_rd, 32'hFFFF_CCDD);
    xact(1'b0, 3'b101, 32'h20, 32'h0);
    chk("lhu_rd", t_rd, 32'h0000_CCDD);

    xact(1'b1, 3'b000, 32'h24, 32'h1234_5678);
    chk("sb_strb", 32'(t_strb), 32'h1);
    chk("sb_wd", t_wd, 32'h1234_5678);

    xact(1'b0, 3'b011, 32'h10, 32'h0);
    chk("ill_ld_lat", 32'(t_lat), 32'd1);
    chk("ill_ld_err", 32'(t_err), 32'd1);
    chk("ill_ld_en", 32'(t_en), 32'd0);
    xact(1'b1, 3'b100, 32'h10, 32'h0);
    chk("ill_st_err", 32'(t_err), 32'd1);
    chk("ill_st_en", 32'(t_en), 32'd0);

    m_lat_cfg = 99;
    xact(1'b0, 3'b010, 32'h10, 32'h0);
    chk("to_ld_lat", 32'(t_lat), 32'd17);
    chk("to_ld_en", 32'(t_en), 32'd16);
    chk("to_ld_err", 32'(t_err), 32'd1);
    chk("to_ld_rd", t_rd, 32'h0);
    xact(1'b1, 3'b010, 32'h10, 32'h0);
    chk("to_st_lat", 32'(t_lat), 32'd17);
    chk("to_st_err", 32'(t_err), 32'd1);

    m_lat_cfg = 15;
    xact(1'b0, 3'b010, 32'h10, 32'h0);
    chk("edge_lat", 32'(t_lat), 32'd17);
    chk("edge_err", 32'(t_err), 32'd0);
    chk("edge_rd", t_rd, 32'h3322_1180);
    m_lat_cfg = 1;

    @(negedge clk);
    m_stray = 1'b1;
    n_seen  = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (resp_valid) n_seen++;
    end
    @(negedge clk);
    m_stray = 1'b0;
    chk("stray_rv", 32'(n_seen), 32'd0);
    chk("stray_rdy", 32'(req_ready), 32'd1);

    xact(1'b0, 3'b010, 32'h22, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lat", 32'(t_lat), 32'd1);
    chk("mis_err", 32'(t_err), 32'd1);
    chk("mis_en", 32'(t_en), 32'd0);
`else
    chk("mis_lat", 32'(t_lat), 32'd3);
    chk("mis_err", 32'(t_err), 32'd0);
    chk("mis_addr", t_addr, 32'h22);
`endif

    m_lat_cfg = 99;
    @(negedge clk);
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_re", 32'(mem_read_enable), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_re_rst", 32'(mem_read_enable), 32'd0);
    chk("mid_rv_rst", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mid_rdy", 32'(req_ready), 32'd1);
    n_seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (resp_valid || mem_read_enable) n_seen++;
    end
    chk("mid_quiet", 32'(n_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
